// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit with architectural HI/LO and a busy flag.
// Define MD_UNIT_MADD_EN to enable madd/maddu (mdop 7/8) accumulating into {hi,lo}.
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  mdop,
   input  logic [31:0] opa,
   input  logic [31:0] opb,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [3:0] MD_MULT  = 4'd1;
   localparam logic [3:0] MD_MULTU = 4'd2;
   localparam logic [3:0] MD_DIV   = 4'd3;
   localparam logic [3:0] MD_DIVU  = 4'd4;
   localparam logic [3:0] MD_MTHI  = 4'd5;
   localparam logic [3:0] MD_MTLO  = 4'd6;
`ifdef MD_UNIT_MADD_EN
   localparam logic [3:0] MD_MADD  = 4'd7;
   localparam logic [3:0] MD_MADDU = 4'd8;
`endif

   localparam logic [4:0] MC = 5'(MULT_CYCLES);
   localparam logic [4:0] DC = 5'(DIV_CYCLES);

   logic        r_busy;
   logic [4:0]  r_cnt;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic [63:0] r_pend;
   logic        r_pend_we;

   logic [63:0] w_sprod;
   logic [63:0] w_uprod;
   logic        w_sdiv;
   logic        w_na;
   logic        w_nb;
   logic [31:0] w_ua;
   logic [31:0] w_ub;
   logic [31:0] w_dv;
   logic [31:0] w_uq;
   logic [31:0] w_ur;
   logic [31:0] w_q;
   logic [31:0] w_r;

   logic        w_valid;
   logic        w_long;
   logic [4:0]  w_ld;
   logic [63:0] w_res;
   logic        w_we;
   logic        w_acc;

   assign w_sprod = {{32{opa[31]}}, opa} * {{32{opb[31]}}, opb};
   assign w_uprod = {32'd0, opa} * {32'd0, opb};

   // Divide on magnitudes, then restore signs: quotient truncates to zero,
   // remainder follows the dividend. Zero divisor is masked to keep values known.
   assign w_sdiv = (mdop == MD_DIV);
   assign w_na   = w_sdiv & opa[31];
   assign w_nb   = w_sdiv & opb[31];
   assign w_ua   = w_na ? (~opa + 32'd1) : opa;
   assign w_ub   = w_nb ? (~opb + 32'd1) : opb;
   assign w_dv   = (w_ub == 32'd0) ? 32'd1 : w_ub;
   assign w_uq   = w_ua / w_dv;
   assign w_ur   = w_ua % w_dv;
   assign w_q    = (w_na ^ w_nb) ? (~w_uq + 32'd1) : w_uq;
   assign w_r    = w_na ? (~w_ur + 32'd1) : w_ur;

   always_comb begin
      w_valid = 1'b0;
      w_long  = 1'b0;
      w_ld    = 5'd0;
      w_res   = 64'd0;
      w_we    = 1'b0;
      case (mdop)
         MD_MULT: begin
            w_valid = 1'b1;
            w_long  = 1'b1;
            w_ld    = MC;
            w_res   = w_sprod;
            w_we    = 1'b1;
         end
         MD_MULTU: begin
            w_valid = 1'b1;
            w_long  = 1'b1;
            w_ld    = MC;
            w_res   = w_uprod;
            w_we    = 1'b1;
         end
         MD_DIV, MD_DIVU: begin
            w_valid = 1'b1;
            w_long  = 1'b1;
            w_ld    = DC;
            w_res   = {w_r, w_q};
            w_we    = (opb != 32'd0);
         end
         MD_MTHI, MD_MTLO: begin
            w_valid = 1'b1;
         end
`ifdef MD_UNIT_MADD_EN
         MD_MADD: begin
            w_valid = 1'b1;
            w_long  = 1'b1;
            w_ld    = MC;
            w_res   = {r_hi, r_lo} + w_sprod;
            w_we    = 1'b1;
         end
         MD_MADDU: begin
            w_valid = 1'b1;
            w_long  = 1'b1;
            w_ld    = MC;
            w_res   = {r_hi, r_lo} + w_uprod;
            w_we    = 1'b1;
         end
`endif
         default: begin
            w_valid = 1'b0;
         end
      endcase
   end

   assign w_acc = start & ~r_busy & w_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_busy    <= 1'b0;
         r_cnt     <= 5'd0;
         r_hi      <= 32'd0;
         r_lo      <= 32'd0;
         r_pend    <= 64'd0;
         r_pend_we <= 1'b0;
      end else if (w_acc) begin
         if (w_long) begin
            r_busy    <= 1'b1;
            r_cnt     <= w_ld;
            r_pend    <= w_res;
            r_pend_we <= w_we;
         end else if (mdop == MD_MTHI) begin
            r_hi <= opa;
         end else begin
            r_lo <= opa;
         end
      end else if (r_busy) begin
         r_cnt <= r_cnt - 5'd1;
         // Last count: commit the result (unless divide-by-zero) and go idle.
         if (r_cnt == 5'd1) begin
            r_busy <= 1'b0;
            if (r_pend_we) begin
               r_hi <= r_pend[63:32];
               r_lo <= r_pend[31:0];
            end
         end
      end
   end

   assign busy = r_busy;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus queues expected HI/LO and busy length,
// a negedge monitor checks hold behaviour and pops at each completion.
module tb_md_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  mdop;
   logic [31:0] opa;
   logic [31:0] opb;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   typedef struct {
      logic [31:0] old_hi;
      logic [31:0] old_lo;
      logic [31:0] new_hi;
      logic [31:0] new_lo;
      int          cyc;
   } exp_t;

   exp_t        q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] cur_hi = 32'd0;
   logic [31:0] cur_lo = 32'd0;
   logic        prev_busy = 1'b0;
   int          bcnt = 0;

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .start(start), .mdop(mdop),
      .opa(opa), .opb(opb), .busy(busy), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         prev_busy = 1'b0;
         bcnt = 0;
      end else begin
         if (busy) begin
            bcnt++;
            if (q.size() > 0) begin
               chk("hold_hi", hi, q[0].old_hi);
               chk("hold_lo", lo, q[0].old_lo);
            end
         end
         if (prev_busy && !busy) begin
            if (q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("busy_len", bcnt, e.cyc);
               chk("res_hi", hi, e.new_hi);
               chk("res_lo", lo, e.new_lo);
            end
            bcnt = 0;
         end
         prev_busy = busy;
      end
   end

   task automatic expect_op(input logic [31:0] nh, input logic [31:0] nl,
                            input int cyc);
      exp_t e;
      e.old_hi = cur_hi;
      e.old_lo = cur_lo;
      e.new_hi = nh;
      e.new_lo = nl;
      e.cyc    = cyc;
      q.push_back(e);
      cur_hi = nh;
      cur_lo = nl;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      @(posedge clk); #1;
      start = 1'b1; mdop = op; opa = a; opb = b;
      @(posedge clk); #1;
      start = 1'b0; mdop = 4'd0;
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk); #1;
         if (!busy && q.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         chk("idle_timeout", 32'd1, 32'd0);
         q.delete();
      end
   endtask

   // mthi then mtlo on consecutive edges, checking each one cycle later
   task automatic mv(input logic [31:0] h, input logic [31:0] l);
      @(posedge clk); #1;
      start = 1'b1; mdop = 4'd5; opa = h;
      @(posedge clk); #1;
      chk("mthi_hi", hi, h);
      chk("mthi_busy", {31'd0, busy}, 32'd0);
      mdop = 4'd6; opa = l;
      @(posedge clk); #1;
      start = 1'b0; mdop = 4'd0;
      chk("mtlo_lo", lo, l);
      chk("mtlo_hi", hi, h);
      chk("mtlo_busy", {31'd0, busy}, 32'd0);
      cur_hi = h;
      cur_lo = l;
   endtask

   task automatic noop(input logic [3:0] op);
      issue(op, 32'hAAAA5555, 32'h3);
      chk("noop_busy", {31'd0, busy}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("noop_hi", hi, cur_hi);
      chk("noop_lo", lo, cur_lo);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; mdop = 4'd0; opa = 32'd0; opb = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);

      mv(32'h1234, 32'h5678);

      expect_op(32'hFFFFFFFF, 32'hFFFFFFFA, 5);
      issue(4'd1, 32'hFFFFFFFE, 32'd3);
      wait_idle();

      expect_op(32'd2, 32'd14, 10);
      issue(4'd4, 32'd100, 32'd7);
      wait_idle();

      expect_op(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
      issue(4'd3, 32'hFFFFFFF9, 32'd2);
      wait_idle();

      expect_op(32'd0, 32'h80000000, 10);
      issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
      wait_idle();

      mv(32'h11, 32'h22);
      expect_op(32'h11, 32'h22, 10);
      issue(4'd3, 32'd5, 32'd0);
      wait_idle();

      // mthi arriving two edges after multu is accepted must be dropped
      expect_op(32'd0, 32'd6, 5);
      @(posedge clk); #1;
      start = 1'b1; mdop = 4'd2; opa = 32'd2; opb = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; mdop = 4'd5; opa = 32'hDEAD;
      @(posedge clk); #1;
      start = 1'b0; mdop = 4'd0;
      wait_idle();
      chk("busy_ign_hi", hi, 32'd0);
      chk("busy_ign_lo", lo, 32'd6);

      noop(4'd0);
      noop(4'd9);
`ifdef MD_UNIT_MADD_EN
      mv(32'd0, 32'hFFFFFFFF);
      expect_op(32'd1, 32'd0, 5);
      issue(4'd8, 32'd1, 32'd1);
      wait_idle();
`else
      noop(4'd7);
      noop(4'd8);
`endif

      mv(32'h1234, 32'h5678);
      expect_op(32'd2, 32'd14, 10);
      issue(4'd3, 32'd100, 32'd7);
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_hi", hi, 32'd0);
      chk("arst_lo", lo, 32'd0);
      q.delete();
      cur_hi = 32'd0;
      cur_lo = 32'd0;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
      chk("post_rst_hi", hi, 32'd0);
      chk("post_rst_lo", lo, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the E stage, directly downstream of the D->E pipeline register.
- Consumes the E-stage operands (rfrd1_E/rfrd2_E after forwarding) plus a decoded op code.
- Produces the architectural HI/LO registers and a busy flag for the hazard unit.
- Models multi-cycle latency so the hazard unit must stall md instructions while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high for mult/multu (legal range 1..31).
- DIV_CYCLES, 10, cycles busy stays high for div/divu (legal range 1..31).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  issue strobe from E-stage decode; sampled at posedge
- mdop  input  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7/8 as under Optional Feature; others reserved
- opa  input  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo source)
- opb  input  32  forwarded rt operand (divisor / multiplier)
- busy  output  1  operation in flight
- hi  output  32  architectural HI register
- lo  output  32  architectural LO register

Behaviour:
- Reset (async, any time including mid-operation): busy=0, hi=0, lo=0, cycle counter=0, pending result=0. The in-flight op is discarded.
- Accept rule: start is honoured only at a posedge where busy=0 and mdop is valid. start with busy=1 is ignored; the hazard unit stalls on (busy | start) with md ops. start with mdop=0 or a reserved code is a no-op.
- mult/multu: at the accept edge T, compute the 64-bit product (signed / unsigned) into pending {hi,lo} and load counter=MULT_CYCLES. busy=1 from T. Each later edge decrements the counter. At edge T+MULT_CYCLES, hi/lo take the pending value, busy=0.
- div/divu: identical timing using DIV_CYCLES.
  - lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed): lo=0x80000000, hi=0.
- Divide by zero (opb=0): busy still runs DIV_CYCLES; hi/lo unchanged at completion.
- hi/lo hold their old values throughout busy. They change only at the completion edge, never mid-operation.
- mthi/mtlo: single-cycle. At the accept edge, hi (resp. lo) <= opa, and busy stays 0. Back-to-back mthi/mtlo in consecutive cycles are all accepted.
- A new op may be accepted at the edge right after the completion edge. At the completion edge itself busy is still 1, so start is ignored.
- Counter width is 5 bits. It never wraps: it loads only on accept and stops at 0.
- Outputs are pure registers; there is no combinational path from inputs to hi/lo/busy.

Optional Feature:
- Macro: MD_UNIT_MADD_EN.
- Defined:
  - mdop 7 = madd: {hi,lo} + signed(opa*opb).
  - mdop 8 = maddu: unsigned equivalent, 64-bit wraparound.
  - Timing is identical to mult. The accumulate uses the {hi,lo} value at the accept edge.
- Undefined: codes 7/8 are reserved, treated as no-op with start ignored, and no accumulate logic is synthesised.

Test Plan:
- Reset mid-divide: start div opa=100 opb=7, assert reset at cycle 3 -> busy=0, hi=0, lo=0 immediately (asynchronous); no later update.
- mult signed: opa=0xFFFFFFFE (-2), opb=3 -> busy high exactly 5 cycles; hi/lo hold old values meanwhile; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- divu and div:
  - divu opa=100, opb=7 -> after 10 cycles lo=14, hi=2.
  - div opa=-7 (0xFFFFFFF9), opb=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Edge cases:
  - div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
  - div by 0 with hi=0x11, lo=0x22 -> busy 10 cycles, then hi=0x11, lo=0x22.
- Start during busy: issue multu 2*3, then issue mthi opa=0xDEAD at cycle 2 -> mthi ignored; after completion hi=0, lo=6.
- mthi/mtlo: mthi opa=0x1234 then mtlo opa=0x5678 on consecutive edges -> busy never asserts; hi=0x1234, lo=0x5678 one cycle after each.
- Optional feature: with MD_UNIT_MADD_EN, hi=0, lo=0xFFFFFFFF, maddu opa=1 opb=1 -> hi=1, lo=0 after 5 cycles.
